// File: rtl/fpmul_pkg.sv
// Shared types and constants for the floating-point multiplier initiator.
package fpmul_pkg;

    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_ERR_WORD = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_GAP,
        ST_SEND_B,
        ST_START,
        ST_WAIT_RES,
        ST_ACK,
        ST_DELIVER
    } fpmul_init_state_t;

    // States in which the initiator waits on the multiplier and may stall.
    function automatic logic is_watched(input fpmul_init_state_t s);
        return (s == ST_SEND_A) || (s == ST_SEND_B) || (s == ST_WAIT_RES);
    endfunction

endpackage

// File: rtl/fpmul_wdog.sv
// Watchdog down-counter: reloads while load_i is high, counts while en_i is
// high, and flags expiry when the count has run out with the enable still set.
module fpmul_wdog #(
    parameter int CW    = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: reload outside the watched window, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(LIMIT - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CW'(LIMIT - 1);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && !load_i && (cnt_q == '0);

endmodule

// File: rtl/fpmul_initiator.sv
// Requester-side controller for the 32-bit FP multiplier: sends A then B over
// the operand bus, pulses startMul, collects the product and hands it to the
// host on a valid/ready port.
// Optional watchdog on the wait states: define FPMUL_INIT_TIMEOUT_EN.
module fpmul_initiator
    import fpmul_pkg::*;
#(
    parameter int W              = FP_W,
    parameter int START_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         op_ready,
    output logic [W-1:0] IN,
    output logic         inReady,
    input  logic         Accept,
    output logic         startMul,
    input  logic         resultready,
    input  logic [W-1:0] ResultBus,
    output logic         resultaccepted,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    input  logic         res_ready,
    output logic         err
);

    localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    if (START_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("fpmul_initiator: START_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    fpmul_init_state_t state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [W-1:0]      b_q, b_d;
    logic [W-1:0]      res_q, res_d;
    logic [SC_W-1:0]   scnt_q, scnt_d;
    logic              wd_expire;

`ifdef FPMUL_INIT_TIMEOUT_EN
    localparam int WD_RAW = $clog2(TIMEOUT_CYCLES);
    localparam int WD_W   = (WD_RAW < 8) ? 8 : ((WD_RAW > 16) ? 16 : WD_RAW);

    logic err_q, err_d;

    // Every entry to a watched state comes from an unwatched one, so reloading
    // outside the window restarts the count on each entry.
    fpmul_wdog #(
        .CW    (WD_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .load_i   (!is_watched(state_q)),
        .en_i     (is_watched(state_q)),
        .expire_o (wd_expire)
    );

    assign err = err_q;
`else
    assign wd_expire = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state and datapath update; handshake events take priority over expiry.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        scnt_d  = scnt_q;
`ifdef FPMUL_INIT_TIMEOUT_EN
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    state_d = ST_SEND_A;
                end
            end
            ST_SEND_A: begin
                if (Accept) state_d = ST_GAP;
            end
            ST_GAP: begin
                state_d = ST_SEND_B;
            end
            ST_SEND_B: begin
                if (Accept) begin
                    scnt_d  = SC_W'(START_CYCLES - 1);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (scnt_q == '0) state_d = ST_WAIT_RES;
                else              scnt_d  = scnt_q - 1'b1;
            end
            ST_WAIT_RES: begin
                if (resultready) begin
                    res_d   = ResultBus;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_DELIVER;
            end
            ST_DELIVER: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
`ifdef FPMUL_INIT_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (wd_expire && (state_d == state_q)) begin
            state_d = ST_DELIVER;
            res_d   = W'(FP_ERR_WORD);
`ifdef FPMUL_INIT_TIMEOUT_EN
            err_d   = 1'b1;
`endif
        end
    end

    // State and data registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            scnt_q  <= '0;
`ifdef FPMUL_INIT_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            scnt_q  <= scnt_d;
`ifdef FPMUL_INIT_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    // Outputs decode the state register only; IN shows A until B's turn.
    assign op_ready       = (state_q == ST_IDLE);
    assign inReady        = (state_q == ST_SEND_A) || (state_q == ST_SEND_B);
    assign startMul       = (state_q == ST_START);
    assign resultaccepted = (state_q == ST_ACK);
    assign res_valid      = (state_q == ST_DELIVER);
    assign IN             = (state_q == ST_SEND_B) ? b_q : a_q;
    assign res_data       = res_q;

endmodule

// File: tb/tb_fpmul_initiator.sv
// Randomized bench for fpmul_initiator with a behavioural multiplier responder.
module tb_fpmul_initiator;

    localparam int W              = 32;
    localparam int START_CYCLES   = 2;
    localparam int TIMEOUT_CYCLES = 20;
`ifdef FPMUL_INIT_TIMEOUT_EN
    localparam int RES_BASIC = 15;
`else
    localparam int RES_BASIC = 30;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         op_valid, op_ready, inReady, Accept, startMul;
    logic         resultready, resultaccepted, res_valid, res_ready, err;
    logic [W-1:0] op_a, op_b, IN, ResultBus, res_data;

    int checks   = 0;
    int failures = 0;
    int txn_no   = 0;

    // responder configuration
    int          acc_dly, res_dly;
    logic [31:0] res_word;
    bit          spur, res_never;

    // observations of the current transaction
    logic [31:0] words[$];
    logic [31:0] in_first;
    int gap_cnt, gap_bad, in_unstable, sm_cycles, sm_early, ra_cycles, wr_cycles;
    int wcnt, rcnt;
    bit in_seen, sm_done, prev_sm, rr_done;

    fpmul_initiator #(
        .W              (W),
        .START_CYCLES   (START_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .op_valid       (op_valid),
        .op_a           (op_a),
        .op_b           (op_b),
        .op_ready       (op_ready),
        .IN             (IN),
        .inReady        (inReady),
        .Accept         (Accept),
        .startMul       (startMul),
        .resultready    (resultready),
        .ResultBus      (ResultBus),
        .resultaccepted (resultaccepted),
        .res_valid      (res_valid),
        .res_data       (res_data),
        .res_ready      (res_ready),
        .err            (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        words.delete();
        gap_cnt = 0; gap_bad = 0; in_unstable = 0; sm_cycles = 0; sm_early = 0;
        ra_cycles = 0; wr_cycles = 0; wcnt = 0; rcnt = 0;
        in_seen = 0; sm_done = 0; prev_sm = 0; rr_done = 0; in_first = '0;
    endtask

    // Multiplier model plus protocol monitor, acting on falling edges.
    initial begin
        Accept = 1'b0; resultready = 1'b0; ResultBus = '0;
        clear_mon();
        forever begin
            @(negedge clk);
            if (rst) begin
                clear_mon();
                Accept = 1'b0;
                resultready = 1'b0;
            end else begin
                Accept = 1'b0;
                if (inReady) begin
                    if (!in_seen) begin
                        in_seen = 1; in_first = IN; wcnt = 0;
                    end else if (IN !== in_first) begin
                        in_unstable++;
                    end
                    if (wcnt >= acc_dly) begin
                        Accept = 1'b1;
                        words.push_back(IN);
                    end else begin
                        wcnt++;
                    end
                end else begin
                    in_seen = 0;
                    if (words.size() == 1) begin
                        gap_cnt++;
                        if (IN !== words[0]) gap_bad++;
                    end
                    if (spur) Accept = 1'($urandom_range(0, 1));
                end
                if (startMul) begin
                    sm_cycles++;
                    if (words.size() != 2) sm_early++;
                end
                if (prev_sm && !startMul) sm_done = 1;
                prev_sm = startMul;
                if (resultaccepted) begin
                    ra_cycles++;
                    rr_done = 1;
                end
                if (sm_done && !rr_done && !res_valid) wr_cycles++;
                resultready = 1'b0;
                ResultBus = res_word;
                if (sm_done && !rr_done && !res_never) begin
                    if (rcnt >= res_dly) resultready = 1'b1;
                    else rcnt++;
                end else if (spur && inReady) begin
                    resultready = 1'($urandom_range(0, 1));
                    ResultBus = $urandom;
                end
            end
        end
    end

    task automatic issue_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk); #2;
        clear_mon();
        check_eq("op_ready_idle", {31'd0, op_ready}, 32'd1);
        op_a = a; op_b = b; op_valid = 1'b1;
        @(negedge clk); #2;
        op_valid = 1'b0; op_a = $urandom; op_b = $urandom;
    endtask

    task automatic wait_deliver();
        int n = 0;
        while (res_valid !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        #1;
        check_eq("deliver_seen", {31'd0, res_valid}, 32'd1);
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                           input int ad, input int rd, input int hold, input bit sp);
        logic [31:0] w0, w1;
        int bad = 0;
        acc_dly = ad; res_dly = rd; res_word = r; spur = sp; res_never = 0;
        res_ready = (hold == 0);
        issue_op(a, b);
        wait_deliver();
        w0 = (words.size() > 0) ? words[0] : 'x;
        w1 = (words.size() > 1) ? words[1] : 'x;
        check_eq("word_count", words.size(), 32'd2);
        check_eq("word_a", w0, a);
        check_eq("word_b", w1, b);
        check_eq("gap_cycles", gap_cnt, 32'd1);
        check_eq("gap_holds_a", gap_bad, 32'd0);
        check_eq("in_stable", in_unstable, 32'd0);
        check_eq("startmul_len", sm_cycles, START_CYCLES);
        check_eq("startmul_early", sm_early, 32'd0);
        check_eq("ack_len", ra_cycles, 32'd1);
        check_eq("wait_cycles", wr_cycles, rd + 1);
        check_eq("res_data", res_data, r);
        check_eq("err_clear", {31'd0, err}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            op_valid = 1'b1; op_a = $urandom; op_b = $urandom;
            if (res_valid !== 1'b1 || res_data !== r || op_ready !== 1'b0) bad++;
            @(negedge clk); #1;
        end
        if (hold > 0) check_eq("hold_stable", bad, 32'd0);
        op_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk); #1;
        check_eq("back_idle", {29'd0, op_ready, res_valid, inReady}, 32'b100);
        $display("txn %0d a=%08h b=%08h res=%08h got=%08h acc_dly=%0d res_dly=%0d hold=%0d spur=%0d",
                 txn_no, a, b, r, res_data, ad, rd, hold, sp);
        txn_no++;
        spur = 0;
    endtask

    task automatic reset_mid();
        int n = 0;
        acc_dly = 1; res_dly = 5; res_word = $urandom; spur = 0; res_never = 0; res_ready = 1'b1;
        issue_op($urandom, $urandom);
        while (startMul !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_reach_start", {31'd0, startMul}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_async_ctl", {26'd0, op_ready, inReady, startMul, resultaccepted, res_valid, err},
                 32'b100000);
        check_eq("rst_async_in", IN, 32'd0);
        check_eq("rst_async_res", res_data, 32'd0);
        $display("txn %0d reset asserted in START", txn_no);
        txn_no++;
        @(negedge clk); @(negedge clk); #2;
        rst = 1'b0;
    endtask

`ifdef FPMUL_INIT_TIMEOUT_EN
    task automatic timeout_txn();
        acc_dly = 2; res_dly = 0; res_word = $urandom; spur = 0; res_never = 1; res_ready = 1'b0;
        issue_op($urandom, $urandom);
        wait_deliver();
        check_eq("to_err", {31'd0, err}, 32'd1);
        check_eq("to_data", res_data, 32'hFFFFFFFF);
        check_eq("to_wait_cycles", wr_cycles, TIMEOUT_CYCLES);
        check_eq("to_no_ack", ra_cycles, 32'd0);
        res_ready = 1'b1;
        @(negedge clk); #1;
        check_eq("to_err_cleared", {30'd0, err, op_ready}, 32'b01);
        $display("txn %0d timeout delivered %08h", txn_no, 32'hFFFFFFFF);
        txn_no++;
        res_never = 0;
    endtask
`endif

    initial begin
        op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
        acc_dly = 1; res_dly = 0; res_word = '0; spur = 0; res_never = 0;
        #1 rst = 1'b1;
        #2;
        check_eq("reset_ctl", {26'd0, op_ready, inReady, startMul, resultaccepted, res_valid, err},
                 32'b100000);
        check_eq("reset_in", IN, 32'd0);
        check_eq("reset_res", res_data, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        run_txn(32'h3FC00000, 32'h40000000, 32'h40400000, 1, RES_BASIC, 0, 0);
        run_txn($urandom, $urandom, $urandom, 7, 3, 0, 0);
        run_txn($urandom, $urandom, $urandom, 2, 4, 10, 0);
        run_txn($urandom, $urandom, $urandom, 1, 6, 2, 1);
        for (int i = 0; i < 8; i++) begin
            run_txn($urandom, $urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 12),
                    $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end
        reset_mid();
        run_txn($urandom, $urandom, $urandom, 1, 2, 1, 0);
`ifdef FPMUL_INIT_TIMEOUT_EN
        timeout_txn();
        run_txn($urandom, $urandom, $urandom, 0, 1, 0, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
